player_action_ctrl: RTL and testbench

//  Per-player action controller sitting directly downstream of input_handler.

---
 rtl/player_action_ctrl_if.sv | 27 ++
 rtl/player_action_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_player_action_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/player_action_ctrl_if.sv
// Handshake bundle between one player's debounced inputs and its action controller.
// The slave modport belongs to the controller. The master modport belongs to whoever drives the buttons and tick.
interface player_action_ctrl_if #(
   parameter int POS_W = 8
);
   logic             i_tick;
   logic             i_freeze;
   logic             i_btn_left;
   logic             i_btn_right;
   logic             i_btn_attack;
   logic [POS_W-1:0] o_pos;
   logic             o_facing_right;
   logic [1:0]       o_phase;
   logic             o_attack_active;
   logic             o_attack_start;
   logic             o_busy;

   modport slave (
      input  i_tick, i_freeze, i_btn_left, i_btn_right, i_btn_attack,
      output o_pos, o_facing_right, o_phase, o_attack_active, o_attack_start, o_busy
   );

   modport master (
      output i_tick, i_freeze, i_btn_left, i_btn_right, i_btn_attack,
      input  o_pos, o_facing_right, o_phase, o_attack_active, o_attack_start, o_busy
   );
endinterface

// File: rtl/player_action_ctrl.sv
// Per-player action controller. It handles tick-paced horizontal movement with wall saturation.
// It also runs a WINDUP/ACTIVE/RECOVER attack sequence, started by an edge-detected attack button.
module player_action_ctrl #(
   parameter int POS_W     = 8,
   parameter int POS_MIN   = 0,
   parameter int POS_MAX   = 159,
   parameter int POS_INIT  = 0,
   parameter int FACE_INIT = 1,
   parameter int STEP      = 2,
   parameter int MOVE_DIV  = 2,
   parameter int WINDUP_T  = 3,
   parameter int ACTIVE_T  = 2,
   parameter int RECOVER_T = 4
) (
   input logic                  clk,
   input logic                  reset,
   player_action_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      PH_IDLE    = 2'd0,
      PH_WINDUP  = 2'd1,
      PH_ACTIVE  = 2'd2,
      PH_RECOVER = 2'd3
   } phase_t;

   typedef enum logic [1:0] {
      DIR_NONE  = 2'd0,
      DIR_RIGHT = 2'd1,
      DIR_LEFT  = 2'd2
   } dir_t;

   localparam int PH_MAX = (WINDUP_T > ACTIVE_T) ?
                           ((WINDUP_T > RECOVER_T) ? WINDUP_T : RECOVER_T) :
                           ((ACTIVE_T > RECOVER_T) ? ACTIVE_T : RECOVER_T);
   localparam int CNT_W  = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
   localparam int MV_W   = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

   // Phase counters are loaded with T-1 so the entry tick counts as the first tick of the phase.
   localparam logic [CNT_W-1:0] WINDUP_LD  = CNT_W'(WINDUP_T - 1);
   localparam logic [CNT_W-1:0] ACTIVE_LD  = CNT_W'(ACTIVE_T - 1);
   localparam logic [CNT_W-1:0] RECOVER_LD = CNT_W'(RECOVER_T - 1);
   localparam logic [MV_W-1:0]  MV_LAST    = MV_W'(MOVE_DIV - 1);
   localparam logic [POS_W:0]   MAX_X      = (POS_W+1)'(POS_MAX);
   localparam logic [POS_W:0]   LO_LIM_X   = (POS_W+1)'(POS_MIN + STEP);
   localparam logic [POS_W:0]   STEP_X     = (POS_W+1)'(STEP);

   phase_t           r_phase;
   logic [CNT_W-1:0] r_ph_cnt;
   logic [POS_W-1:0] r_pos;
   logic             r_facing;
   logic [MV_W-1:0]  r_mv_cnt;
   dir_t             r_dir;
   logic             r_pending;
   logic             r_attack_q;
   logic             r_attack_start;

   phase_t           w_phase_nxt;
   logic [CNT_W-1:0] w_ph_cnt_nxt;
   logic [POS_W-1:0] w_pos_nxt;
   logic             w_facing_nxt;
   logic [MV_W-1:0]  w_mv_cnt_nxt;
   dir_t             w_dir_nxt;
   logic             w_pending_nxt;
   logic             w_attack_start_nxt;
   dir_t             w_dir;
   logic             w_valid_tick;
   logic             w_rise;
   logic             w_start;
   logic [POS_W:0]   w_pos_ext;
   logic [POS_W:0]   w_pos_up;
   logic [POS_W-1:0] w_pos_step;

   assign w_valid_tick = bus.i_tick & ~bus.i_freeze;
   assign w_rise       = bus.i_btn_attack & ~r_attack_q;
   assign w_start      = w_valid_tick & (r_phase == PH_IDLE) & r_pending;
   assign w_pos_ext    = {1'b0, r_pos};
   assign w_pos_up     = w_pos_ext + STEP_X;

   // Direction decode and saturating step target for the current direction.
   always_comb begin
      w_dir      = DIR_NONE;
      w_pos_step = r_pos;
      if (bus.i_btn_right && !bus.i_btn_left) begin
         w_dir      = DIR_RIGHT;
         w_pos_step = (w_pos_up > MAX_X) ? POS_W'(POS_MAX) : w_pos_up[POS_W-1:0];
      end else if (bus.i_btn_left && !bus.i_btn_right) begin
         w_dir      = DIR_LEFT;
         w_pos_step = (w_pos_ext < LO_LIM_X) ? POS_W'(POS_MIN) : (r_pos - POS_W'(STEP));
      end else begin
         w_dir      = DIR_NONE;
         w_pos_step = r_pos;
      end
   end

   // Attack phase FSM and the pending flag (pending is consumed before a same-clk rise can re-arm it).
   always_comb begin
      w_phase_nxt        = r_phase;
      w_ph_cnt_nxt       = r_ph_cnt;
      w_attack_start_nxt = 1'b0;
      if (w_valid_tick) begin
         case (r_phase)
            PH_IDLE: begin
               if (r_pending) begin
                  w_phase_nxt        = PH_WINDUP;
                  w_ph_cnt_nxt       = WINDUP_LD;
                  w_attack_start_nxt = 1'b1;
               end else begin
                  w_phase_nxt = PH_IDLE;
               end
            end
            PH_WINDUP: begin
               if (r_ph_cnt == '0) begin
                  w_phase_nxt  = PH_ACTIVE;
                  w_ph_cnt_nxt = ACTIVE_LD;
               end else begin
                  w_ph_cnt_nxt = r_ph_cnt - CNT_W'(1);
               end
            end
            PH_ACTIVE: begin
               if (r_ph_cnt == '0) begin
                  w_phase_nxt  = PH_RECOVER;
                  w_ph_cnt_nxt = RECOVER_LD;
               end else begin
                  w_ph_cnt_nxt = r_ph_cnt - CNT_W'(1);
               end
            end
            PH_RECOVER: begin
               if (r_ph_cnt == '0) begin
                  w_phase_nxt  = PH_IDLE;
                  w_ph_cnt_nxt = '0;
               end else begin
                  w_ph_cnt_nxt = r_ph_cnt - CNT_W'(1);
               end
            end
            default: begin
               w_phase_nxt  = PH_IDLE;
               w_ph_cnt_nxt = '0;
            end
         endcase
      end else begin
         w_phase_nxt  = r_phase;
         w_ph_cnt_nxt = r_ph_cnt;
      end

      if (bus.i_freeze) begin
         w_pending_nxt = 1'b0;
      end else if (w_start) begin
         w_pending_nxt = 1'b0;
      end else if (w_rise && (r_phase == PH_IDLE)) begin
         w_pending_nxt = 1'b1;
      end else begin
         w_pending_nxt = r_pending;
      end
   end

   // Movement. A fresh direction restarts the divider without counting, so the first step lands MOVE_DIV ticks later.
   always_comb begin
      w_pos_nxt    = r_pos;
      w_facing_nxt = r_facing;
      w_mv_cnt_nxt = r_mv_cnt;
      w_dir_nxt    = r_dir;
      if (!w_valid_tick) begin
         w_mv_cnt_nxt = r_mv_cnt;
      end else if ((r_phase != PH_IDLE) || r_pending || (w_dir == DIR_NONE)) begin
         w_mv_cnt_nxt = '0;
         w_dir_nxt    = DIR_NONE;
      end else begin
         w_facing_nxt = (w_dir == DIR_RIGHT);
         w_dir_nxt    = w_dir;
         if (w_dir != r_dir) begin
            w_mv_cnt_nxt = '0;
         end else if (r_mv_cnt == MV_LAST) begin
            w_mv_cnt_nxt = '0;
            w_pos_nxt    = w_pos_step;
         end else begin
            w_mv_cnt_nxt = r_mv_cnt + MV_W'(1);
         end
      end
   end

   // State registers. Reset aborts any attack in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_phase        <= PH_IDLE;
         r_ph_cnt       <= '0;
         r_pos          <= POS_W'(POS_INIT);
         r_facing       <= (FACE_INIT != 0);
         r_mv_cnt       <= '0;
         r_dir          <= DIR_NONE;
         r_pending      <= 1'b0;
         r_attack_q     <= 1'b0;
         r_attack_start <= 1'b0;
      end else begin
         r_phase        <= w_phase_nxt;
         r_ph_cnt       <= w_ph_cnt_nxt;
         r_pos          <= w_pos_nxt;
         r_facing       <= w_facing_nxt;
         r_mv_cnt       <= w_mv_cnt_nxt;
         r_dir          <= w_dir_nxt;
         r_pending      <= w_pending_nxt;
         r_attack_q     <= bus.i_btn_attack;
         r_attack_start <= w_attack_start_nxt;
      end
   end

   assign bus.o_pos           = r_pos;
   assign bus.o_facing_right  = r_facing;
   assign bus.o_phase         = r_phase;
   assign bus.o_attack_active = (r_phase == PH_ACTIVE);
   assign bus.o_attack_start  = r_attack_start;
   assign bus.o_busy          = (r_phase != PH_IDLE);

endmodule

// File: tb/tb_player_action_ctrl.sv
// Directed bench for player_action_ctrl. Expected per-tick outputs are queued as stimulus is driven.
// They are checked after each tick.
module tb_player_action_ctrl;

   typedef struct {
      string tag;
      int    pos;
      int    face;
      int    phase;
   } exp_t;

   logic clk;
   logic reset;
   int   errors;
   int   checks;
   int   act_cnt;
   exp_t sb[$];

   player_action_ctrl_if #(.POS_W(8)) bus ();

   player_action_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input int pos, input int face, input int phase);
      exp_t e;
      e.tag   = tag;
      e.pos   = pos;
      e.face  = face;
      e.phase = phase;
      sb.push_back(e);
   endtask

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One frame tick, then pop and compare the queued expectation.
   task automatic do_tick();
      exp_t e;
      bus.i_tick = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.i_tick = 1'b0;
      if (bus.o_attack_active) act_cnt++;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         chk({e.tag, "_pos"},    32'(bus.o_pos),           32'(e.pos));
         chk({e.tag, "_face"},   32'(bus.o_facing_right),  32'(e.face));
         chk({e.tag, "_phase"},  32'(bus.o_phase),         32'(e.phase));
         chk({e.tag, "_active"}, 32'(bus.o_attack_active), (e.phase == 2) ? 32'd1 : 32'd0);
         chk({e.tag, "_busy"},   32'(bus.o_busy),          (e.phase != 0) ? 32'd1 : 32'd0);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_pos"},    32'(bus.o_pos),           32'd0);
      chk({tag, "_face"},   32'(bus.o_facing_right),  32'd1);
      chk({tag, "_phase"},  32'(bus.o_phase),         32'd0);
      chk({tag, "_active"}, 32'(bus.o_attack_active), 32'd0);
      chk({tag, "_start"},  32'(bus.o_attack_start),  32'd0);
      chk({tag, "_busy"},   32'(bus.o_busy),          32'd0);
   endtask

   initial begin
      int t1 [6];
      int ph3 [9];
      int p;
      errors  = 0;
      checks  = 0;
      act_cnt = 0;
      t1  = '{0, 0, 2, 2, 4, 4};
      ph3 = '{1, 1, 1, 2, 2, 3, 3, 3, 3};

      reset            = 1'b1;
      bus.i_tick       = 1'b0;
      bus.i_freeze     = 1'b0;
      bus.i_btn_left   = 1'b0;
      bus.i_btn_right  = 1'b0;
      bus.i_btn_attack = 1'b0;
      cycle();
      cycle();
      chk_reset_vals("reset");
      reset = 1'b0;
      cycle();

      // Hold right: moves every second tick, then saturates at the right wall.
      bus.i_btn_right = 1'b1;
      for (int i = 0; i < 6; i++) begin
         push("move_right", t1[i], 1, 0);
         do_tick();
      end
      for (int t = 7; t <= 170; t++) begin
         p = 2 * ((t - 1) / 2);
         if (p > 159) p = 159;
         push("wall_right", p, 1, 0);
         do_tick();
      end
      bus.i_btn_right = 1'b0;
      bus.i_btn_left  = 1'b1;
      push("wall_turn", 159, 0, 0);
      do_tick();
      push("left_hold", 159, 0, 0);
      do_tick();
      push("left_step", 157, 0, 0);
      do_tick();
      bus.i_btn_left = 1'b0;

      // Attack sequence with a discarded second rise during ACTIVE.
      bus.i_btn_attack = 1'b1;
      cycle();
      push("atk1_t1", 157, 0, ph3[0]);
      do_tick();
      chk("atk1_start_pulse", 32'(bus.o_attack_start), 32'd1);
      cycle();
      chk("atk1_start_clear", 32'(bus.o_attack_start), 32'd0);
      bus.i_btn_right = 1'b1;
      for (int i = 1; i < 4; i++) begin
         push("atk1_phase", 157, 0, ph3[i]);
         do_tick();
      end
      bus.i_btn_attack = 1'b0;
      cycle();
      bus.i_btn_attack = 1'b1;
      cycle();
      for (int i = 4; i < 9; i++) begin
         push("atk1_phase", 157, 0, ph3[i]);
         do_tick();
      end
      bus.i_btn_right = 1'b0;
      chk("atk1_active_ticks", 32'(act_cnt), 32'd2);
      push("atk1_idle", 157, 0, 0);
      do_tick();
      push("held_no_retrig", 157, 0, 0);
      do_tick();
      push("held_no_retrig", 157, 0, 0);
      do_tick();

      // Fresh rise starts a new attack; reset in RECOVER aborts it.
      bus.i_btn_attack = 1'b0;
      cycle();
      bus.i_btn_attack = 1'b1;
      cycle();
      push("atk2_t1", 157, 0, 1);
      do_tick();
      chk("atk2_start_pulse", 32'(bus.o_attack_start), 32'd1);
      for (int i = 1; i < 6; i++) begin
         push("atk2_phase", 157, 0, ph3[i]);
         do_tick();
      end
      bus.i_btn_attack = 1'b0;
      bus.i_btn_left   = 1'b1;
      bus.i_btn_right  = 1'b1;
      reset = 1'b1;
      cycle();
      chk_reset_vals("mid_reset");
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         push("both_held", 0, 1, 0);
         do_tick();
      end
      bus.i_btn_right = 1'b0;

      // Freeze: ticks ignored, rise rejected, facing held even with left pressed.
      bus.i_freeze     = 1'b1;
      bus.i_btn_attack = 1'b1;
      cycle();
      for (int i = 0; i < 5; i++) begin
         push("frozen", 0, 1, 0);
         do_tick();
      end
      bus.i_freeze   = 1'b0;
      bus.i_btn_left = 1'b0;
      for (int i = 0; i < 3; i++) begin
         push("unfrozen_idle", 0, 1, 0);
         do_tick();
      end

      // Pending set while IDLE, then cleared by a freeze before any tick.
      bus.i_btn_attack = 1'b0;
      cycle();
      bus.i_btn_attack = 1'b1;
      cycle();
      bus.i_freeze = 1'b1;
      cycle();
      bus.i_freeze = 1'b0;
      push("freeze_clr_pend", 0, 1, 0);
      do_tick();

      // Left wall: turning left at POS_MIN holds position.
      bus.i_btn_left = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push("wall_left", 0, 0, 0);
         do_tick();
      end
      bus.i_btn_left = 1'b0;

      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
